// File: rtl/if_gb_responder_if.sv
// GB <-> interface-responder handshake bundle.
// Carries the GB request channel (cfg), the GB write-burst channel (wr) and
// the read-return channel (rd).
//   master : GB side (drives GBIF_*, observes IFGB_*)
//   slave  : responder side (observes GBIF_*, drives IFGB_*)
interface if_gb_responder_if #(
    parameter int unsigned PORT_WIDTH = 128
);
    logic                  GBIF_cfg_val;
    logic [3:0]            GBIF_cfg_info;
    logic                  IFGB_cfg_rdy;

    logic                  GBIF_wr_val;
    logic [PORT_WIDTH-1:0] GBIF_wr_data;
    logic                  IFGB_wr_rdy;

    logic                  IFGB_rd_val;
    logic [PORT_WIDTH-1:0] IFGB_rd_data;
    logic                  GBIF_rd_rdy;

    modport master (
        output GBIF_cfg_val, GBIF_cfg_info, GBIF_wr_val, GBIF_wr_data, GBIF_rd_rdy,
        input  IFGB_cfg_rdy, IFGB_wr_rdy, IFGB_rd_val, IFGB_rd_data
    );

    modport slave (
        input  GBIF_cfg_val, GBIF_cfg_info, GBIF_wr_val, GBIF_wr_data, GBIF_rd_rdy,
        output IFGB_cfg_rdy, IFGB_wr_rdy, IFGB_rd_val, IFGB_rd_data
    );
endinterface

// File: rtl/if_gb_responder.sv
// Interface-side responder for GB transfers.
// Accepts GB requests, drains GB write bursts into a memory port and streams
// memory read bursts back to the GB through a small return FIFO. Per-stream
// base/length descriptors live in an 8-entry table programmed by host logic.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   gb                GB handshake bundle (cfg / wr / rd channels), slave side
//   tbl_we/id/base/len descriptor table write port
//   mem_wr_en/rd_en   memory strobes (mutually exclusive), shared mem_addr
//   mem_wr_data       memory write data
//   mem_rd_data       memory read data, valid one cycle after mem_rd_en
//   busy              a burst is active
//   xfer_done         one-cycle pulse after a burst completes
module if_gb_responder #(
    parameter int unsigned PORT_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    if_gb_responder_if.slave      gb,
    input  logic                  tbl_we,
    input  logic [2:0]            tbl_id,
    input  logic [ADDR_WIDTH-1:0] tbl_base,
    input  logic [LEN_WIDTH-1:0]  tbl_len,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [PORT_WIDTH-1:0] mem_wr_data,
    input  logic [PORT_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  xfer_done
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] tbl_base_q [8];
    logic [LEN_WIDTH-1:0]  tbl_len_q  [8];

    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;     // write beat count in WR, read issue count in RD
    logic [LEN_WIDTH-1:0]  sent_q;
    logic [CntW-1:0]       credit_q;  // reads in flight + FIFO occupancy
    logic                  rd_pend_q; // a memory read returns this cycle

    logic [PORT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [CntW-1:0]       fcount_q;

    logic                  xfer_done_q;

    logic                  accept, wr_beat, rd_issue, rd_pop, fifo_nempty, done_set;
    logic [LEN_WIDTH-1:0]  acc_len;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Handshake decode
    assign acc_len     = tbl_len_q[gb.GBIF_cfg_info[2:0]];
    assign accept      = gb.GBIF_cfg_val && (state_q == StIdle);
    assign wr_beat     = (state_q == StWr) && gb.GBIF_wr_val;
    assign rd_issue    = (state_q == StRd) && (cnt_q < len_q) && (credit_q < CntW'(FIFO_DEPTH));
    assign fifo_nempty = (fcount_q != '0);
    assign rd_pop      = fifo_nempty && gb.GBIF_rd_rdy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_done_q <= done_set;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (acc_len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d = gb.GBIF_cfg_info[3] ? StWr : StRd;
                    end
                end
            end
            StWr: begin
                if (wr_beat && (cnt_q == len_q - LEN_WIDTH'(1))) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end
            end
            StRd: begin
                if (rd_pop && (sent_q == len_q - LEN_WIDTH'(1))) begin
                    state_d  = StIdle;
                    done_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        gb.IFGB_cfg_rdy = (state_q == StIdle);
        gb.IFGB_wr_rdy  = (state_q == StWr);
        gb.IFGB_rd_val  = fifo_nempty;
        gb.IFGB_rd_data = fifo_nempty ? fifo_mem[rptr_q] : '0;
        mem_wr_en       = wr_beat;
        mem_rd_en       = rd_issue;
        mem_addr        = (wr_beat || rd_issue) ? base_q + ADDR_WIDTH'(cnt_q) : '0;
        mem_wr_data     = wr_beat ? gb.GBIF_wr_data : '0;
        busy            = (state_q != StIdle);
        xfer_done       = xfer_done_q;
    end

    // Descriptor table, burst context, counters and FIFO control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                tbl_base_q[i] <= '0;
                tbl_len_q[i]  <= '0;
            end
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            sent_q    <= '0;
            credit_q  <= '0;
            rd_pend_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fcount_q  <= '0;
        end else begin
            if (tbl_we) begin
                tbl_base_q[tbl_id] <= tbl_base;
                tbl_len_q[tbl_id]  <= tbl_len;
            end
            // Accept samples the table before this edge's write lands
            if (accept) begin
                base_q <= tbl_base_q[gb.GBIF_cfg_info[2:0]];
                len_q  <= acc_len;
                cnt_q  <= '0;
                sent_q <= '0;
            end else begin
                if (wr_beat || rd_issue) begin
                    cnt_q <= cnt_q + LEN_WIDTH'(1);
                end
                if (rd_pop) begin
                    sent_q <= sent_q + LEN_WIDTH'(1);
                end
            end
            credit_q  <= credit_q + CntW'(rd_issue) - CntW'(rd_pop);
            rd_pend_q <= rd_issue;
            if (rd_pend_q) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (rd_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            fcount_q <= fcount_q + CntW'(rd_pend_q) - CntW'(rd_pop);
        end
    end

    // Return FIFO storage; credits guarantee it never overflows
    always_ff @(posedge clk) begin
        if (rd_pend_q) begin
            fifo_mem[wptr_q] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_if_gb_responder.sv
module tb_if_gb_responder;

    localparam int unsigned PW = 128;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          tbl_we;
    logic [2:0]    tbl_id;
    logic [AW-1:0] tbl_base;
    logic [LW-1:0] tbl_len;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wr_data;
    logic [PW-1:0] mem_rd_data;
    logic          busy, xfer_done;

    if_gb_responder_if #(.PORT_WIDTH(PW)) gb_if ();

    if_gb_responder #(
        .PORT_WIDTH(PW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gb         (gb_if),
        .tbl_we     (tbl_we),
        .tbl_id     (tbl_id),
        .tbl_base   (tbl_base),
        .tbl_len    (tbl_len),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .busy       (busy),
        .xfer_done  (xfer_done)
    );

    always #5 clk = ~clk;

    // Memory model: data = address ^ 0xA5, one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= PW'(mem_addr ^ 16'h00A5);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard queues (cycle -1 = timing not checked)
    logic [AW-1:0] exp_wa [$];
    logic [PW-1:0] exp_wd [$];
    int            exp_wc [$];
    logic [AW-1:0] exp_ra [$];
    logic [PW-1:0] exp_rd [$];
    int            exp_rc [$];
    int            exp_dc [$];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, PW'(act), PW'(exp));
    endtask

    function automatic logic [PW-1:0] wdata(input int i);
        return {96'hD0D1_D2D3_D4D5_D6D7_D8D9_DADB, 32'(i)};
    endfunction

    // Monitor
    logic [AW-1:0] m_a;
    logic [PW-1:0] m_d;
    int            m_c;
    int            issued, popped;
    bit            prev_stall;
    logic [PW-1:0] prev_data;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            issued     = 0;
            popped     = 0;
            prev_stall = 1'b0;
        end else begin
            chk1("mem_excl", mem_wr_en && mem_rd_en, 1'b0);
            if (mem_wr_en) begin
                chk1("mem_wr_queued", exp_wa.size() > 0, 1'b1);
                if (exp_wa.size() > 0) begin
                    m_a = exp_wa.pop_front();
                    m_d = exp_wd.pop_front();
                    m_c = exp_wc.pop_front();
                    chk("mem_wr_addr", PW'(mem_addr), PW'(m_a));
                    chk("mem_wr_data", mem_wr_data, m_d);
                    if (m_c >= 0) chk("mem_wr_cycle", PW'(cyc), PW'(m_c));
                end
            end
            if (mem_rd_en) begin
                chk1("rd_credit", (issued - popped) < 4, 1'b1);
                chk1("mem_rd_queued", exp_ra.size() > 0, 1'b1);
                if (exp_ra.size() > 0) begin
                    m_a = exp_ra.pop_front();
                    chk("mem_rd_addr", PW'(mem_addr), PW'(m_a));
                end
                issued++;
            end
            if (prev_stall) begin
                chk1("stall_val", gb_if.IFGB_rd_val, 1'b1);
                chk("stall_data", gb_if.IFGB_rd_data, prev_data);
            end
            if (gb_if.IFGB_rd_val && gb_if.GBIF_rd_rdy) begin
                chk1("rd_beat_queued", exp_rd.size() > 0, 1'b1);
                if (exp_rd.size() > 0) begin
                    m_d = exp_rd.pop_front();
                    m_c = exp_rc.pop_front();
                    chk("rd_data", gb_if.IFGB_rd_data, m_d);
                    if (m_c >= 0) chk("rd_cycle", PW'(cyc), PW'(m_c));
                end
                popped++;
            end
            if (xfer_done) begin
                chk1("done_queued", exp_dc.size() > 0, 1'b1);
                if (exp_dc.size() > 0) begin
                    m_c = exp_dc.pop_front();
                    if (m_c >= 0) chk("done_cycle", PW'(cyc), PW'(m_c));
                end
                chk1("done_cfg_rdy", gb_if.IFGB_cfg_rdy, 1'b1);
            end
            prev_stall = gb_if.IFGB_rd_val && !gb_if.GBIF_rd_rdy;
            prev_data  = gb_if.IFGB_rd_data;
        end
    end

    task automatic check_idle_outputs(input string pfx);
        chk1({pfx, "_cfg_rdy"}, gb_if.IFGB_cfg_rdy, 1'b1);
        chk1({pfx, "_wr_rdy"}, gb_if.IFGB_wr_rdy, 1'b0);
        chk1({pfx, "_rd_val"}, gb_if.IFGB_rd_val, 1'b0);
        chk({pfx, "_rd_data"}, gb_if.IFGB_rd_data, '0);
        chk1({pfx, "_mem_wr_en"}, mem_wr_en, 1'b0);
        chk1({pfx, "_mem_rd_en"}, mem_rd_en, 1'b0);
        chk({pfx, "_mem_addr"}, PW'(mem_addr), '0);
        chk({pfx, "_mem_wr_data"}, mem_wr_data, '0);
        chk1({pfx, "_busy"}, busy, 1'b0);
        chk1({pfx, "_xfer_done"}, xfer_done, 1'b0);
    endtask

    task automatic tbl_write(input logic [2:0] id, input logic [AW-1:0] base,
                             input logic [LW-1:0] len);
        @(posedge clk); #1;
        tbl_we = 1'b1; tbl_id = id; tbl_base = base; tbl_len = len;
        @(posedge clk); #1;
        tbl_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (xfer_done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: xfer_done absent after 100 cycles, required 1", name);
    endtask

    // len is the length the accept is expected to use; collide writes the
    // same table entry in the accept cycle, which must not affect the burst.
    task automatic do_write(input logic [2:0] id, input logic [AW-1:0] base, input int len,
                            input bit collide);
        int t;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        gb_if.GBIF_cfg_val  = 1'b1;
        gb_if.GBIF_cfg_info = {1'b1, id};
        if (collide) begin
            tbl_we = 1'b1; tbl_id = id; tbl_base = 16'h7777; tbl_len = 10'd5;
        end
        @(negedge clk);
        chk1("wr_cfg_rdy", gb_if.IFGB_cfg_rdy, 1'b1);
        t = cyc;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_wa.push_back(a);
            exp_wd.push_back(wdata(i));
            exp_wc.push_back(t + 1 + i);
        end
        exp_dc.push_back(t + len + 1);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            gb_if.GBIF_cfg_val = 1'b0;
            tbl_we             = 1'b0;
            gb_if.GBIF_wr_val  = 1'b1;
            gb_if.GBIF_wr_data = wdata(i);
        end
        @(posedge clk); #1;
        gb_if.GBIF_wr_val  = 1'b0;
        gb_if.GBIF_wr_data = '0;
        wait_done("wr");
    endtask

    task automatic do_reset_mid();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        exp_wa.delete(); exp_wd.delete(); exp_wc.delete();
        exp_ra.delete(); exp_rd.delete(); exp_rc.delete(); exp_dc.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // toggle: rd_rdy follows 1,0,0,1; abort_after>0: reset after that many beats
    task automatic do_read(input logic [2:0] id, input logic [AW-1:0] base, input int len,
                           input bit toggle, input int abort_after);
        int t, beats, k;
        logic [AW-1:0] a;
        logic [3:0] pat;
        pat = 4'b1001;
        @(posedge clk); #1;
        gb_if.GBIF_cfg_val  = 1'b1;
        gb_if.GBIF_cfg_info = {1'b0, id};
        gb_if.GBIF_rd_rdy   = !toggle;
        @(negedge clk);
        chk1("rd_cfg_rdy", gb_if.IFGB_cfg_rdy, 1'b1);
        t = cyc;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            exp_ra.push_back(a);
            exp_rd.push_back(PW'(a ^ 16'h00A5));
            exp_rc.push_back(toggle ? -1 : t + 3 + i);
        end
        exp_dc.push_back(len == 0 ? t + 1 : (toggle ? -1 : t + 3 + len));
        beats = 0;
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            gb_if.GBIF_cfg_val = 1'b0;
            if (toggle) gb_if.GBIF_rd_rdy = pat[k % 4];
            @(negedge clk);
            if (gb_if.IFGB_rd_val && gb_if.GBIF_rd_rdy) beats++;
            if (abort_after != 0 && beats == abort_after) begin
                do_reset_mid();
                return;
            end
            if (xfer_done) break;
        end
        if (k == 200) begin
            checks++;
            errors++;
            $display("FAIL rd_timeout: xfer_done absent after 200 cycles, required 1");
        end
        @(posedge clk); #1;
        gb_if.GBIF_rd_rdy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst                 = 1'b1;
        tbl_we              = 1'b0;
        tbl_id              = '0;
        tbl_base            = '0;
        tbl_len             = '0;
        gb_if.GBIF_cfg_val  = 1'b0;
        gb_if.GBIF_cfg_info = '0;
        gb_if.GBIF_wr_val   = 1'b0;
        gb_if.GBIF_wr_data  = '0;
        gb_if.GBIF_rd_rdy   = 1'b0;
        #2;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Stray write data while idle must be ignored
        @(posedge clk); #1;
        gb_if.GBIF_wr_val  = 1'b1;
        gb_if.GBIF_wr_data = wdata(99);
        @(posedge clk); #1;
        gb_if.GBIF_wr_val  = 1'b0;

        tbl_write(3'd2, 16'h0100, 10'd4);
        do_write(3'd2, 16'h0100, 4, 1'b0);

        tbl_write(3'd5, 16'h0200, 10'd8);
        do_read(3'd5, 16'h0200, 8, 1'b0, 0);
        do_read(3'd5, 16'h0200, 8, 1'b1, 0);

        tbl_write(3'd0, 16'h0040, 10'd0);
        do_read(3'd0, 16'h0040, 0, 1'b0, 0);

        tbl_write(3'd1, 16'hFFFE, 10'd4);
        do_write(3'd1, 16'hFFFE, 4, 1'b0);

        tbl_write(3'd3, 16'h0300, 10'd2);
        do_write(3'd3, 16'h0300, 2, 1'b1);

        // Reset after 3 of 8 beats; the table is cleared so ID5 completes as len 0
        do_read(3'd5, 16'h0200, 8, 1'b0, 3);
        do_read(3'd5, 16'h0200, 0, 1'b0, 0);

        tbl_write(3'd2, 16'h0100, 10'd4);
        do_write(3'd2, 16'h0100, 4, 1'b0);
        tbl_write(3'd5, 16'h0200, 10'd8);
        do_read(3'd5, 16'h0200, 8, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained",
            PW'(exp_wa.size() + exp_ra.size() + exp_rd.size() + exp_dc.size()), '0);
        chk1("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
